// File: rtl/dp_tpp_uram_drain_pkg.sv
// Shared definitions for the tap drain: BRAM delay, dp_tpp_mode encodings and drain FSM states.
// Row latency and flow control live in the modules that import this package.
`ifndef COMMON_BRAM_DELAY
`define COMMON_BRAM_DELAY 2
`endif
`ifndef S_AXI_NTT_MADD
`define S_AXI_NTT_MADD 2'd0
`endif
`ifndef S_NTT_MADD_AXI
`define S_NTT_MADD_AXI 2'd1
`endif
`ifndef S_MADD_AXI_NTT
`define S_MADD_AXI_NTT 2'd2
`endif

package dp_tpp_uram_drain_pkg;

  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_RUN  = 2'd1,
    DRAIN_WAIT = 2'd2
  } drain_state_e;

  // In this mode the tap is shared with NTT reads and only usable once NTT is done.
  localparam logic [1:0] MODE_SHARED = `S_MADD_AXI_NTT;

endpackage

// File: rtl/dp_sync_fifo.sv
// Generic synchronous FIFO with occupancy count and synchronous clear; registered state, data readable from head the cycle after push.
// Push when full and pop when empty are ignored; the producer is expected to hold credit.
module dp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dp_tpp_uram_drain.sv
// Drains the temp/URAM tap row by row onto valid/ready; first beat RD_LATENCY+1 cycles after the first issue, reads held back by FIFO credit.
// Define DP_TPP_DRAIN_STALL_CNT_EN to build the saturating stall counter on o_stall_cnt.
`ifndef COMMON_BRAM_DELAY
`define COMMON_BRAM_DELAY 2
`endif

module dp_tpp_uram_drain
  import dp_tpp_uram_drain_pkg::*;
#(
  parameter int COE_WIDTH     = 39,
  parameter int ADDR_WIDTH    = 9,
  parameter int NUM_POLY      = 3,
  parameter int NUM_BASE_BANK = 8,
  parameter int RD_LATENCY    = `COMMON_BRAM_DELAY,
  parameter int FIFO_DEPTH    = 4,
  localparam int DW           = COE_WIDTH * NUM_BASE_BANK * NUM_POLY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic                  i_ntt_done,
  output logic [ADDR_WIDTH-1:0] o_uram_rdaddr,
  output logic                  o_rd_issue,
  input  logic [DW-1:0]         i_uram_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DW-1:0]         o_data,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_abort,
  output logic [15:0]           o_stall_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  drain_state_e          state_q, state_d;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [RD_LATENCY-1:0] dl_vld, dl_last;
  logic                  done_q, done_d;
  logic                  issue, abort, start_acc, pop, tap_ok, credit_ok, final_addr;
  logic [7:0]            inflight, fifo_free;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [DW:0]           fifo_dout;

  assign tap_ok     = (mode_q != MODE_SHARED) || i_ntt_done;
  assign final_addr = &addr_q;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + {7'd0, dl_vld[i]};
  end

  // Every issued read must already own a FIFO slot when its data lands.
  assign fifo_free = 8'(FIFO_DEPTH) - 8'(fifo_cnt);
  assign credit_ok = fifo_free > inflight;

  assign o_valid = !fifo_empty;
  assign pop     = o_valid && i_ready;
  assign o_data  = o_valid ? fifo_dout[DW-1:0] : '0;
  assign o_last  = o_valid && fifo_dout[DW];

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    abort     = 1'b0;
    start_acc = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      DRAIN_IDLE: begin
        if (i_start) begin
          start_acc = 1'b1;
          state_d   = DRAIN_RUN;
        end
      end
      DRAIN_RUN: begin
        if (i_mode != mode_q) begin
          abort   = 1'b1;
          state_d = DRAIN_IDLE;
        end else if (tap_ok && credit_ok) begin
          issue = 1'b1;
          if (final_addr) state_d = DRAIN_WAIT;
        end
      end
      DRAIN_WAIT: begin
        if (i_mode != mode_q) begin
          abort   = 1'b1;
          state_d = DRAIN_IDLE;
        end else if (pop && fifo_dout[DW]) begin
          done_d  = 1'b1;
          state_d = DRAIN_IDLE;
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DRAIN_IDLE;
      mode_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_acc) begin
        mode_q <= i_mode;
        addr_q <= '0;
      end else if (issue && !final_addr) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld  <= '0;
      dl_last <= '0;
    end else if (abort) begin
      dl_vld  <= '0;
      dl_last <= '0;
    end else begin
      dl_vld[0]  <= issue;
      dl_last[0] <= issue && final_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        dl_vld[i]  <= dl_vld[i-1];
        dl_last[i] <= dl_last[i-1];
      end
    end
  end

  dp_sync_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (abort),
    .push     (dl_vld[RD_LATENCY-1]),
    .push_dat ({dl_last[RD_LATENCY-1], i_uram_data}),
    .pop      (pop),
    .pop_dat  (fifo_dout),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

`ifdef DP_TPP_DRAIN_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (o_valid && !i_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign o_stall_cnt = stall_q;
`else
  assign o_stall_cnt = '0;
`endif

  assign o_uram_rdaddr = addr_q;
  assign o_rd_issue    = issue;
  assign o_busy        = (state_q != DRAIN_IDLE);
  assign o_done        = done_q;
  assign o_abort       = abort;

endmodule
